// File: rtl/mii_mac_tx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mii_pkg : shared types and constants for the MII MAC transmitter     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package mii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_PAD      = 3'd3,
    ST_FCS      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_t;

  localparam logic [3:0]  MII_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0]  MII_SFD_NIB      = 4'hD;
  localparam logic [31:0] CRC32_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

endpackage
`default_nettype wire

// File: rtl/mii_mac_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mii_mac_tx_if : 8-bit AXI-stream payload channel into the MII MAC TX |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
interface mii_mac_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/mii_mac_tx_crc32_byte.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | crc32_byte : combinational reflected CRC-32 update for one byte      |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module crc32_byte
  import mii_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;

  always_comb begin
    w_crc = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[0] ? ((w_crc >> 1) ^ CRC32_POLY) : (w_crc >> 1);
    end
    crc_out = w_crc;
  end

endmodule
`default_nettype wire

// File: rtl/mii_mac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mii_mac_tx : AXI-stream to MII transmitter (preamble, pad, FCS, IFG) |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module mii_mac_tx
  import mii_pkg::*;
#(
  parameter bit ENABLE_PADDING   = 1'b1,
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int IFG_NIBBLES      = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  mii_mac_tx_if.slave  s_axis,
  output logic [3:0]   mii_txd,
  output logic         mii_tx_en,
  output logic         mii_tx_er,
  output logic         start_packet,
  output logic         error_underflow
);

  localparam logic [15:0] PAD_BYTES = 16'(MIN_FRAME_LENGTH - 4);
  localparam logic [15:0] IFG_LAST  = 16'(IFG_NIBBLES - 1);

  tx_state_t   r_state;
  logic [7:0]  r_data;
  logic        r_user;
  logic        r_last;
  logic        r_phase;
  logic [3:0]  r_nib;
  logic [15:0] r_cnt;
  logic [15:0] r_ifg;
  logic [31:0] r_crc;
  logic [3:0]  r_txd;
  logic        r_tx_en;
  logic        r_tx_er;
  logic        r_tready;
  logic        r_start;
  logic        r_underflow;

  logic [31:0] w_crc_next;
  logic        w_accept;

  assign w_accept = s_axis.tvalid && r_tready;

  // Pad bytes reuse the payload path with r_data forced to zero
  crc32_byte u_crc (
    .crc_in  (r_crc),
    .data    (r_data),
    .crc_out (w_crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_data      <= 8'd0;
      r_user      <= 1'b0;
      r_last      <= 1'b0;
      r_phase     <= 1'b0;
      r_nib       <= 4'd0;
      r_cnt       <= 16'd0;
      r_ifg       <= 16'd0;
      r_crc       <= CRC32_INIT;
      r_txd       <= 4'd0;
      r_tx_en     <= 1'b0;
      r_tx_er     <= 1'b0;
      r_tready    <= 1'b0;
      r_start     <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_start     <= 1'b0;
      r_underflow <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tready <= 1'b1;
          if (w_accept) begin
            r_data   <= s_axis.tdata;
            r_user   <= s_axis.tuser;
            r_last   <= s_axis.tlast;
            r_crc    <= CRC32_INIT;
            r_cnt    <= 16'd0;
            r_nib    <= 4'd0;
            r_tready <= 1'b0;
            r_txd    <= MII_PREAMBLE_NIB;
            r_tx_en  <= 1'b1;
            r_tx_er  <= 1'b0;
            r_start  <= 1'b1;
            r_state  <= ST_PREAMBLE;
          end
        end

        ST_PREAMBLE: begin
          r_nib <= r_nib + 4'd1;
          if (r_nib == 4'd14) begin
            r_txd <= MII_SFD_NIB;
          end else if (r_nib == 4'd15) begin
            r_txd   <= r_data[3:0];
            r_tx_er <= r_user;
            r_phase <= 1'b0;
            r_state <= ST_PAYLOAD;
          end else begin
            r_txd <= MII_PREAMBLE_NIB;
          end
        end

        ST_PAYLOAD, ST_PAD: begin
          if (!r_phase) begin
            r_crc    <= w_crc_next;
            r_cnt    <= (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
            r_txd    <= r_data[7:4];
            r_phase  <= 1'b1;
            r_tready <= (r_state == ST_PAYLOAD) && !r_last;
          end else begin
            r_tready <= 1'b0;
            r_phase  <= 1'b0;
            if (r_state == ST_PAYLOAD && !r_last) begin
              if (w_accept) begin
                r_data  <= s_axis.tdata;
                r_user  <= s_axis.tuser;
                r_last  <= s_axis.tlast;
                r_txd   <= s_axis.tdata[3:0];
                r_tx_er <= s_axis.tuser;
              end else begin
                // Underrun: one errored nibble with tx_en still high, then drain
                r_underflow <= 1'b1;
                r_txd       <= 4'd0;
                r_tx_er     <= 1'b1;
                r_tready    <= 1'b1;
                r_state     <= ST_DRAIN;
              end
            end else if (ENABLE_PADDING && (r_cnt < PAD_BYTES)) begin
              r_data  <= 8'd0;
              r_user  <= 1'b0;
              r_txd   <= 4'd0;
              r_tx_er <= 1'b0;
              r_state <= ST_PAD;
            end else begin
              r_nib   <= 4'd0;
              r_txd   <= ~r_crc[3:0];
              r_tx_er <= 1'b0;
              r_state <= ST_FCS;
            end
          end
        end

        ST_FCS: begin
          if (r_nib == 4'd7) begin
            r_tx_en <= 1'b0;
            r_txd   <= 4'd0;
            r_ifg   <= 16'd0;
            r_state <= ST_IFG;
          end else begin
            r_nib <= r_nib + 4'd1;
            r_txd <= ~r_crc[{r_nib[2:0] + 3'd1, 2'b00} +: 4];
          end
        end

        ST_DRAIN: begin
          r_tx_en <= 1'b0;
          r_tx_er <= 1'b0;
          r_txd   <= 4'd0;
          if (w_accept && s_axis.tlast) begin
            r_tready <= 1'b0;
            r_ifg    <= 16'd0;
            r_state  <= ST_IFG;
          end
        end

        ST_IFG: begin
          if (r_ifg == IFG_LAST) begin
            r_tready <= 1'b1;
            r_state  <= ST_IDLE;
          end else begin
            r_ifg <= r_ifg + 16'd1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis.tready   = r_tready;
  assign mii_txd         = r_txd;
  assign mii_tx_en       = r_tx_en;
  assign mii_tx_er       = r_tx_er;
  assign start_packet    = r_start;
  assign error_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_mii_mac_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mii_mac_tx : directed self-checking bench for mii_mac_tx          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_mii_mac_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mii_mac_tx_if axis ();
  logic [3:0] mii_txd;
  logic       mii_tx_en;
  logic       mii_tx_er;
  logic       start_packet;
  logic       error_underflow;

  mii_mac_tx #(
    .ENABLE_PADDING   (1'b1),
    .MIN_FRAME_LENGTH (64),
    .IFG_NIBBLES      (24)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis          (axis.slave),
    .mii_txd         (mii_txd),
    .mii_tx_en       (mii_tx_en),
    .mii_tx_er       (mii_tx_er),
    .start_packet    (start_packet),
    .error_underflow (error_underflow)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // MII line monitor: every tx_en-high nibble is logged as {tx_er, txd}
  logic [4:0] mon_nib[$];
  int fstart[$];
  int flen[$];
  int gaps[$];
  int rise_cyc[$];
  int sp_cyc[$];
  int low_run = 0;
  int uf_cnt = 0;
  logic prev_en = 1'b0;

  always @(negedge clk) begin
    if (mii_tx_en) begin
      if (!prev_en) begin
        fstart.push_back(int'(mon_nib.size()));
        rise_cyc.push_back(cyc);
        gaps.push_back(low_run);
      end
      mon_nib.push_back({mii_tx_er, mii_txd});
      low_run <= 0;
    end else begin
      if (prev_en) flen.push_back(int'(mon_nib.size()) - fstart[fstart.size()-1]);
      low_run <= low_run + 1;
    end
    if (start_packet) sp_cyc.push_back(cyc);
    if (error_underflow) uf_cnt <= uf_cnt + 1;
    prev_en <= mii_tx_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0] pay[$];
  int acc_cyc[$];

  task automatic send(input int drop_at, input int tuser_at, input int stop_at, input bit hold);
    int n;
    int w;
    n = pay.size();
    for (int i = 0; i < n && i < stop_at; i++) begin
      if (i == drop_at) begin
        axis.tvalid = 1'b0;
        repeat (4) @(negedge clk);
      end
      axis.tdata  = pay[i];
      axis.tvalid = 1'b1;
      axis.tlast  = (i == n - 1);
      axis.tuser  = (i == tuser_at);
      w = 0;
      while (!axis.tready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        chk("handshake", {31'd0, axis.tready}, 32'd1);
        axis.tvalid = 1'b0;
        return;
      end
      acc_cyc.push_back(cyc);
      @(negedge clk);
    end
    if (!hold) begin
      axis.tvalid = 1'b0;
      axis.tlast  = 1'b0;
      axis.tuser  = 1'b0;
    end
  endtask

  // Reference nibble stream: preamble, bytes low-nibble first, pad, bit-serial FCS
  logic [4:0] exp_nib[$];

  task automatic build_exp(input int nbytes, input int tuser_at, input bit underflow);
    logic [7:0]  b;
    logic [31:0] c;
    logic        e;
    logic        fb;
    int          total;
    c = 32'hFFFFFFFF;
    exp_nib.delete();
    repeat (15) exp_nib.push_back(5'h05);
    exp_nib.push_back(5'h0D);
    total = underflow ? nbytes : ((nbytes < 60) ? 60 : nbytes);
    for (int i = 0; i < total; i++) begin
      b = (i < nbytes) ? pay[i] : 8'h00;
      e = (i == tuser_at);
      exp_nib.push_back({e, b[3:0]});
      exp_nib.push_back({e, b[7:4]});
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[k];
        c  = {1'b0, c[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    end
    if (underflow) begin
      exp_nib.push_back(5'h10);
    end else begin
      c = ~c;
      for (int k = 0; k < 8; k++) exp_nib.push_back({1'b0, c[4*k +: 4]});
    end
  endtask

  task automatic check_frame(input int fi, input string tag, input bit skip_last);
    int base;
    int len;
    int n;
    int idx;
    for (int w = 0; w < 2000 && flen.size() <= fi; w++) @(negedge clk);
    chk({tag, " done"}, {31'd0, (flen.size() > fi)}, 32'd1);
    if (flen.size() <= fi) return;
    base = fstart[fi];
    len  = flen[fi];
    chk({tag, " tx_en length"}, len, exp_nib.size());
    n = (len < exp_nib.size()) ? len : exp_nib.size();
    if (skip_last) n--;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      if (mon_nib[base+i] !== exp_nib[i]) begin
        idx = i;
        break;
      end
    end
    chk($sformatf("%s nibble %0d", tag, idx), {27'd0, mon_nib[base+idx]}, {27'd0, exp_nib[idx]});
    if (skip_last) chk({tag, " err nibble"}, {31'd0, mon_nib[base+len-1][4]}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fi;
    int a0;
    int uf0;
    int low;
    int ers;

    axis.tdata  = 8'd0;
    axis.tvalid = 1'b0;
    axis.tlast  = 1'b0;
    axis.tuser  = 1'b0;
    repeat (3) @(negedge clk);

    chk("reset txd", {28'd0, mii_txd}, 32'd0);
    chk("reset tx_en", {31'd0, mii_tx_en}, 32'd0);
    chk("reset tx_er", {31'd0, mii_tx_er}, 32'd0);
    chk("reset tready", {31'd0, axis.tready}, 32'd0);
    chk("reset start_packet", {31'd0, start_packet}, 32'd0);
    chk("reset underflow", {31'd0, error_underflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready after release", {31'd0, axis.tready}, 32'd1);

    // 60-byte frame 0x00..0x3B: 144 tx_en cycles and pipeline latencies
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    fi = fstart.size();
    a0 = acc_cyc.size();
    send(-1, -1, 1000, 1'b0);
    build_exp(60, -1, 1'b0);
    check_frame(fi, "f60", 1'b0);
    chk("f60 tx_en rise latency", rise_cyc[fi] - acc_cyc[a0], 32'd1);
    chk("f60 start_packet cycle", sp_cyc[fi], rise_cyc[fi]);
    chk("f60 second tready cycle", acc_cyc[a0+1] - acc_cyc[a0], 32'd18);

    // 10-byte frame padded to 60 bytes
    pay.delete();
    for (int i = 0; i < 10; i++) pay.push_back(8'hC0 + 8'(i));
    fi = fstart.size();
    send(-1, -1, 1000, 1'b0);
    build_exp(10, -1, 1'b0);
    check_frame(fi, "pad10", 1'b0);

    // Two back-to-back 64-byte frames with tvalid held high
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'(i * 3 + 1));
    fi = fstart.size();
    send(-1, -1, 1000, 1'b1);
    send(-1, -1, 1000, 1'b0);
    build_exp(64, -1, 1'b0);
    check_frame(fi, "b2b first", 1'b0);
    check_frame(fi + 1, "b2b second", 1'b0);
    chk("b2b gap", gaps[fi+1], 32'd25);

    // Underrun at byte 20 of 100, remainder drained, then IFG
    pay.delete();
    for (int i = 0; i < 100; i++) pay.push_back(8'(i) ^ 8'h5A);
    fi = fstart.size();
    uf0 = uf_cnt;
    send(20, -1, 1000, 1'b0);
    low = 0;
    while (!axis.tready && low < 100) begin
      @(negedge clk);
      low++;
    end
    chk("underrun ifg length", low, 32'd24);
    build_exp(20, -1, 1'b1);
    check_frame(fi, "underrun", 1'b1);
    chk("underrun pulses", uf_cnt - uf0, 32'd1);
    chk("underrun frames", fstart.size() - fi, 32'd1);

    // tuser on byte 5: tx_er on exactly two nibbles, FCS from clean data
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'h40 + 8'(i));
    fi = fstart.size();
    send(-1, 5, 1000, 1'b0);
    build_exp(64, 5, 1'b0);
    check_frame(fi, "tuser", 1'b0);
    ers = 0;
    if (flen.size() > fi) begin
      for (int i = 0; i < flen[fi]; i++) ers += int'(mon_nib[fstart[fi]+i][4]);
    end
    chk("tuser tx_er nibbles", ers, 32'd2);

    // Reset asserted during payload byte 30, then a clean frame
    pay.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'hFF - 8'(i));
    send(-1, -1, 31, 1'b0);
    chk("pre-reset tx_en", {31'd0, mii_tx_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset txd", {28'd0, mii_txd}, 32'd0);
    chk("async reset tx_en", {31'd0, mii_tx_en}, 32'd0);
    chk("async reset tx_er", {31'd0, mii_tx_er}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("tready at re-release", {31'd0, axis.tready}, 32'd0);
    @(negedge clk);
    chk("tready after re-release", {31'd0, axis.tready}, 32'd1);
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i * 7) ^ 8'hA5);
    fi = fstart.size();
    send(-1, -1, 1000, 1'b0);
    build_exp(60, -1, 1'b0);
    check_frame(fi, "post-reset", 1'b0);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mii_mac_tx.md
# mii_mac_tx

MAC-side MII transmitter: accepts frame payload as an 8-bit AXI-stream and drives the MII transmit pins toward a PHY. It adds preamble/SFD, pads short frames, appends FCS, and enforces inter-frame gap. It sits between the MAC TX FIFO and the PHY `txd`/`tx_en`/`tx_er` pins. It is clocked by the PHY-sourced `tx_clk`.

## Interface
- `ENABLE_PADDING`, 1: pad payload with 0x00 up to `MIN_FRAME_LENGTH`-4 bytes.
- `MIN_FRAME_LENGTH`, 64: minimum frame length in bytes, including FCS.
- `IFG_NIBBLES`, 24: idle nibble cycles after FCS (12 byte times).
- `clk`  in  1: MII transmit clock (PHY `tx_clk`); single clock domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_axis_tdata`  in  8: payload byte.
- `s_axis_tvalid`  in  1: byte valid.
- `s_axis_tready`  out  1: byte accepted when `tvalid && tready`.
- `s_axis_tlast`  in  1: last payload byte of frame.
- `s_axis_tuser`  in  1: bad-frame flag; sampled on every accepted byte.
- `mii_txd`  out  4: transmit nibble.
- `mii_tx_en`  out  1: transmit enable.
- `mii_tx_er`  out  1: transmit error.
- `start_packet`  out  1: one-cycle pulse when the first SFD-preceding nibble is driven.
- `error_underflow`  out  1: one-cycle pulse on payload underrun.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, PAD, FCS, DRAIN, IFG.
- IDLE: `tready`=1. An accepted byte is latched, CRC is initialized, and the next state is PREAMBLE.
- PREAMBLE: 15 nibbles of 0x5, then 1 nibble of 0xD (7×0x55 followed by SFD 0xD5, low nibble first).
- PAYLOAD: each byte occupies 2 cycles, low nibble first. `tready`=1 only on the high-nibble cycle, to fetch the next byte.
  - If no byte arrives (`tvalid`=0) on a high-nibble cycle: pulse `error_underflow`, drive `tx_er`=1 with `tx_en`=1 for one nibble, then go to DRAIN.
- End of payload: after the high nibble of the `tlast` byte:
  - go to PAD if padding is enabled and byte count < `MIN_FRAME_LENGTH`-4;
  - otherwise go to FCS.
- PAD: emit 0x00 bytes until the byte count reaches `MIN_FRAME_LENGTH`-4, then go to FCS.
- FCS: 8 nibbles of ~CRC, byte 0 first, low nibble first.
- CRC-32 rules: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, updated per payload and pad byte.
- DRAIN: `tx_en`=0, `tready`=1. Incoming bytes are discarded through `tlast`, then the state goes to IFG.
- IFG: `tx_en`=0, `tready`=0 for `IFG_NIBBLES` cycles, then back to IDLE.
- `tuser`=1 on an accepted byte: `tx_er`=1 for both nibbles of that byte. The frame otherwise completes normally.
- Byte counter is 16-bit and saturates at 0xFFFF; no jumbo limit is enforced.

## Timing
- Reset values: `txd`=0, `tx_en`=0, `tx_er`=0, `tready`=0, both pulse outputs 0, state IDLE. `tready` rises on the first clock after reset release.
- All MII outputs are registered.
- Cycle sequence for a frame, with the first byte accepted at cycle 0:
  - `tx_en` rises at cycle 1 and `start_packet` pulses at cycle 1;
  - SFD nibble 0xD at cycle 16;
  - first data low nibble at cycle 17; second byte `tready` at cycle 18.
- A frame of N payload bytes (N ≥ 60) holds `tx_en` for 16+2N+8 cycles, followed by `IFG_NIBBLES` idle cycles.
- Back-to-back frames: minimum spacing from `tx_en` fall to the next `tx_en` rise is `IFG_NIBBLES`+1 cycles (includes the IDLE accept cycle).
- `tlast` and underrun cannot coincide: the `tlast` byte ends the fetch sequence.
- Reset mid-frame: outputs clear asynchronously. The partial frame is abandoned, and no FCS or IFG follows.

## Structure
- Package `mii_pkg` holds:
  - state enum;
  - constants `MII_PREAMBLE_NIB`=4'h5, `MII_SFD_NIB`=4'hD, `CRC32_POLY`=32'hEDB88320, `CRC32_INIT`=32'hFFFFFFFF.
- Sub-module `crc32_byte`: combinational byte-wide CRC-32 next-state (crc_in, data → crc_out). The top level holds the CRC register.

## Test plan
- Single 60-byte frame 0x00..0x3B: MII decoder must see 15×0x5, 0xD, 60 bytes, and correct FCS. `tx_en` high for exactly 144 cycles.
- 10-byte frame with padding enabled: 50 bytes of 0x00 are appended, and the FCS covers 60 bytes.
- Two back-to-back 64-byte frames with `tvalid` held high: `tx_en` low for exactly 25 cycles between frames.
- `tvalid` dropped at byte 20 of 100: `error_underflow` pulses, and `tx_er`=1 for one nibble with `tx_en`=1.
  - Remaining bytes are drained through `tlast`, then a 24-cycle IFG follows.
- `tuser`=1 on byte 5: `tx_er` is high on exactly those 2 nibbles, and the FCS is unchanged versus the same frame with `tuser`=0.
- `rst_n` asserted at payload byte 30: `tx_en`/`tx_er`/`txd` go to 0 immediately. After release, a new frame transmits correctly.
